// File: rtl/packet_demux_1to2_pkg.sv
// Shared defaults and port-select encodings for the 1-to-2 packet demultiplexer.
package packet_demux_1to2_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/packet_demux_1to2_sync_fifo.sv
// Single-clock FIFO with occupancy count; a write to a full queue is allowed
// only when a read frees a slot in the same cycle.
module sync_fifo
  import packet_demux_1to2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          full,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Gating on empty gives a zero head word out of reset without clearing the array.
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr && !rst) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + PW'(1);
      end
      if (do_rd) begin
        rptr <= rptr + PW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/packet_demux_1to2.sv
// Steers each inbound word to one of two independent output queues by in_sel.
module packet_demux_1to2
  import packet_demux_1to2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_sel,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         a_data,
  output logic                          a_valid,
  input  logic                          a_ready,
  output logic [DATA_WIDTH-1:0]         b_data,
  output logic                          b_valid,
  input  logic                          b_ready,
  output logic [$clog2(FIFO_DEPTH):0]   a_count,
  output logic [$clog2(FIFO_DEPTH):0]   b_count
);

  logic a_full;
  logic a_empty;
  logic b_full;
  logic b_empty;
  logic sel_b;
  logic a_push;
  logic b_push;

  assign sel_b = (in_sel == PORT_B);

  // A full queue still accepts when its consumer pops in the same cycle.
  assign in_ready = sel_b ? (!b_full || b_ready) : (!a_full || a_ready);

  assign a_push  = in_valid && in_ready && !sel_b;
  assign b_push  = in_valid && in_ready &&  sel_b;
  assign a_valid = !a_empty;
  assign b_valid = !b_empty;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (a_push),
    .wr_data (in_data),
    .full    (a_full),
    .rd_en   (a_ready),
    .rd_data (a_data),
    .empty   (a_empty),
    .count   (a_count)
  );

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (b_push),
    .wr_data (in_data),
    .full    (b_full),
    .rd_en   (b_ready),
    .rd_data (b_data),
    .empty   (b_empty),
    .count   (b_count)
  );

endmodule
